ysyx_22040125_mem_arbiter: RTL

Two-requester arbiter between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the ysyx_22040125 core. It serialises their requests onto the single CPU-side port of the AXI bridge. Each granted request is captured into registers, and bridge enables are held for the whole transaction. The completion pulse and data are routed back to the owner. A per-transaction watchdog turns a hung transaction into an error response.

---
 rtl/ysyx_22040125_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040125_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040125_mem_arbiter
// Description : Serialises IFU and LSU requests onto the single CPU-side port
//               of the AXI bridge. The winner's request is captured into
//               holding registers. The matching bridge enable is held until
//               completion, and the response is routed back to its owner.
//               A per-transaction watchdog turns a hung transaction into an
//               error response.
// Config      : ARB_ROUND_ROBIN_EN - when defined, a tie is granted to the
//               requester that did not win last; otherwise LSU wins ties.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040125_mem_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        aclk,
    input  logic        aresetn,
    // instruction-fetch requester
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ready,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    // load/store requester
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    input  logic [2:0]  lsu_size,
    output logic        lsu_ready,
    output logic        lsu_done,
    output logic [63:0] lsu_rdata,
    output logic        lsu_err,
    // AXI bridge CPU-side port
    output logic        inst_r_en,
    output logic        data_r_en,
    output logic        data_w_en,
    output logic [31:0] inst_addr,
    output logic [31:0] data_r_addr,
    output logic [31:0] data_w_addr,
    output logic [63:0] data_w,
    output logic [7:0]  data_w_mask,
    output logic [2:0]  cpu_arsize,
    output logic [2:0]  cpu_awsize,
    input  logic        inst_r_valid,
    input  logic        data_r_valid,
    input  logic        data_w_valid,
    input  logic [31:0] inst_r,
    input  logic [63:0] data_r
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IFU_BUSY = 2'd1,
        ST_LSU_RD   = 2'd2,
        ST_LSU_WR   = 2'd3
    } state_t;

    localparam logic       GRANT_IFU = 1'b0;
    localparam logic       GRANT_LSU = 1'b1;
    localparam logic [2:0] IFU_SIZE  = 3'b010;
    // The counter holds the number of busy cycles already completed, so the
    // abort fires in the TIMEOUT-th busy cycle and the response follows it.
    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [9:0]  wdog_q, wdog_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [63:0] hold_wdata_q, hold_wdata_d;
    logic [7:0]  hold_wmask_q, hold_wmask_d;
    logic [2:0]  hold_size_q, hold_size_d;
    logic        ifu_rvalid_q, ifu_rvalid_d;
    logic        ifu_err_q, ifu_err_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic        lsu_done_q, lsu_done_d;
    logic        lsu_err_q, lsu_err_d;
    logic [63:0] lsu_rdata_q, lsu_rdata_d;

    logic grant_ifu;
    logic grant_lsu;
    logic wdog_expired;

    assign wdog_expired = (wdog_q == WDOG_LAST);

    // Choose the winner in IDLE; a lone requester is always granted at once.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ifu_req && lsu_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_lsu = (last_grant_q == GRANT_IFU);
                grant_ifu = (last_grant_q == GRANT_LSU);
`else
                grant_lsu = 1'b1;
`endif
            end else begin
                grant_ifu = ifu_req;
                grant_lsu = lsu_req;
            end
        end
    end

    assign ifu_ready = grant_ifu;
    assign lsu_ready = grant_lsu;

    // Next-state, capture, watchdog and response computation.
    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        last_grant_d = last_grant_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_wmask_d = hold_wmask_q;
        hold_size_d  = hold_size_q;
        ifu_rvalid_d = 1'b0;
        ifu_err_d    = 1'b0;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_done_d   = 1'b0;
        lsu_err_d    = 1'b0;
        lsu_rdata_d  = lsu_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_ifu) begin
                    state_d      = ST_IFU_BUSY;
                    wdog_d       = 10'd0;
                    last_grant_d = GRANT_IFU;
                    hold_addr_d  = ifu_addr;
                    hold_wdata_d = 64'h0;
                    hold_wmask_d = 8'h0;
                    hold_size_d  = IFU_SIZE;
                end else if (grant_lsu) begin
                    state_d      = lsu_we ? ST_LSU_WR : ST_LSU_RD;
                    wdog_d       = 10'd0;
                    last_grant_d = GRANT_LSU;
                    hold_addr_d  = lsu_addr;
                    hold_wdata_d = lsu_wdata;
                    hold_wmask_d = lsu_wmask;
                    hold_size_d  = lsu_size;
                end
            end
            ST_IFU_BUSY: begin
                if (inst_r_valid) begin
                    state_d      = ST_IDLE;
                    ifu_rvalid_d = 1'b1;
                    ifu_rdata_d  = inst_r;
                end else if (wdog_expired) begin
                    state_d      = ST_IDLE;
                    ifu_rvalid_d = 1'b1;
                    ifu_err_d    = 1'b1;
                    ifu_rdata_d  = 32'h0;
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            ST_LSU_RD: begin
                if (data_r_valid) begin
                    state_d     = ST_IDLE;
                    lsu_done_d  = 1'b1;
                    lsu_rdata_d = data_r;
                end else if (wdog_expired) begin
                    state_d     = ST_IDLE;
                    lsu_done_d  = 1'b1;
                    lsu_err_d   = 1'b1;
                    lsu_rdata_d = 64'h0;
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            ST_LSU_WR: begin
                // A store returns no data, so the load-data register keeps
                // the last read value on success.
                if (data_w_valid) begin
                    state_d    = ST_IDLE;
                    lsu_done_d = 1'b1;
                end else if (wdog_expired) begin
                    state_d     = ST_IDLE;
                    lsu_done_d  = 1'b1;
                    lsu_err_d   = 1'b1;
                    lsu_rdata_d = 64'h0;
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction silently.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            wdog_q       <= 10'd0;
            last_grant_q <= GRANT_IFU;
            hold_addr_q  <= 32'h0;
            hold_wdata_q <= 64'h0;
            hold_wmask_q <= 8'h0;
            hold_size_q  <= 3'b000;
            ifu_rvalid_q <= 1'b0;
            ifu_err_q    <= 1'b0;
            ifu_rdata_q  <= 32'h0;
            lsu_done_q   <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= 64'h0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            last_grant_q <= last_grant_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_wmask_q <= hold_wmask_d;
            hold_size_q  <= hold_size_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            ifu_err_q    <= ifu_err_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_done_q   <= lsu_done_d;
            lsu_err_q    <= lsu_err_d;
            lsu_rdata_q  <= lsu_rdata_d;
        end
    end

    assign ifu_rvalid = ifu_rvalid_q;
    assign ifu_err    = ifu_err_q;
    assign ifu_rdata  = ifu_rdata_q;
    assign lsu_done   = lsu_done_q;
    assign lsu_err    = lsu_err_q;
    assign lsu_rdata  = lsu_rdata_q;

    // Bridge side is a pure decode of the state and holding registers, so
    // every field is stable for the whole transaction and zero when unused.
    assign inst_r_en   = (state_q == ST_IFU_BUSY);
    assign data_r_en   = (state_q == ST_LSU_RD);
    assign data_w_en   = (state_q == ST_LSU_WR);
    assign inst_addr   = inst_r_en ? hold_addr_q : 32'h0;
    assign data_r_addr = data_r_en ? hold_addr_q : 32'h0;
    assign data_w_addr = data_w_en ? hold_addr_q : 32'h0;
    assign data_w      = data_w_en ? hold_wdata_q : 64'h0;
    assign data_w_mask = data_w_en ? hold_wmask_q : 8'h0;
    assign cpu_arsize  = (inst_r_en || data_r_en) ? hold_size_q : 3'b000;
    assign cpu_awsize  = data_w_en ? hold_size_q : 3'b000;

endmodule
`default_nettype wire
